// File: rtl/dl11_pkg.sv
// dl11_pkg: shared definitions for the multi-channel DL11 register block.
//   Register offsets within a channel's 8-byte window, CSR/RBUF bit
//   positions, the transmit state type and the channel base-address helper.
package dl11_pkg;

    localparam logic [2:0] RCSR_OFS = 3'd0;
    localparam logic [2:0] RBUF_OFS = 3'd2;
    localparam logic [2:0] XCSR_OFS = 3'd4;
    localparam logic [2:0] XBUF_OFS = 3'd6;

    localparam int DONE_BIT = 7;
    localparam int IE_BIT   = 6;
    localparam int OVR_BIT  = 14;
    localparam int ERR_BIT  = 15;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_SEND = 2'd1,
        TX_WAIT = 2'd2
    } tx_state_t;

    // Channel 0 is the console; channels 1.. are packed 8 bytes apart
    // starting at the alternate base.
    function automatic logic [15:0] chan_base(input int k,
                                              input logic [15:0] cons,
                                              input logic [15:0] alt);
        if (k == 0)
            return cons;
        else
            return alt + 16'(8 * (k - 1));
    endfunction

endpackage

// File: rtl/dl11_rx_fifo.sv
// dl11_rx_fifo: per-channel receive FIFO.
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_push, i_data : write one byte (accepted when not full, or when a pop
//                    happens in the same cycle)
//   i_pop          : remove the head (ignored when empty)
//   o_head         : byte at the read pointer (stale when empty)
//   o_full, o_empty: occupancy flags
module dl11_rx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_push,
    input  logic       i_pop,
    input  logic [7:0] i_data,
    output logic [7:0] o_head,
    output logic       o_full,
    output logic       o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic w_pop;
    logic w_push;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd_ptr];

    // A pop in the same cycle frees the slot the push lands in.
    assign w_pop  = i_pop & ~o_empty;
    assign w_push = i_push & (~o_full | w_pop);

    always_ff @(posedge i_clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= i_data;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/dl11_multi.sv
// dl11_multi: NCH-channel DL11 serial line register block.
//   i_clk, i_reset         : clock, synchronous active-high reset
//   i_addr, i_wdata        : latched bus address, write data
//   i_rd, i_wr, i_byte     : one-cycle read/write strobes, byte-write flag
//   o_rdata, o_hit         : combinational read data and address hit
//   i_rx_data, i_rx_valid  : received bytes from uart_rx, one pulse each
//   o_tx_data, o_tx_send   : byte and level send request to uart_tx
//   i_tx_ready             : transmitter idle
//   o_rx_irq, o_tx_irq     : level interrupt requests per channel
module dl11_multi
    import dl11_pkg::*;
#(
    parameter int          NCH        = 2,
    parameter logic [15:0] CONS_ADRS  = 16'o177560,
    parameter logic [15:0] ALT_ADRS   = 16'o176500,
    parameter int          FIFO_DEPTH = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [15:0]      i_addr,
    input  logic [15:0]      i_wdata,
    input  logic             i_rd,
    input  logic             i_wr,
    input  logic             i_byte,
    output logic [15:0]      o_rdata,
    output logic             o_hit,
    input  logic [8*NCH-1:0] i_rx_data,
    input  logic [NCH-1:0]   i_rx_valid,
    output logic [8*NCH-1:0] o_tx_data,
    output logic [NCH-1:0]   o_tx_send,
    input  logic [NCH-1:0]   i_tx_ready,
    output logic [NCH-1:0]   o_rx_irq,
    output logic [NCH-1:0]   o_tx_irq
);

    logic [2:0]        w_ofs;
    logic              w_wr_lo;
    logic [NCH-1:0]    w_sel;
    logic [16*NCH-1:0] w_rd_all;
    logic              w_unused;

    assign w_ofs    = {i_addr[2:1], 1'b0};
    // Word writes and even-byte writes carry the CSR low byte; odd-byte
    // writes only touch the unused high byte and are dropped.
    assign w_wr_lo  = i_wr & (~i_byte | ~i_addr[0]);
    assign w_unused = &{1'b0, i_wdata[15:8]};

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        localparam logic [15:0] BASE = chan_base(k, CONS_ADRS, ALT_ADRS);

        logic      w_empty;
        logic      w_full;
        logic [7:0] w_head;
        logic      w_rbuf_rd;
        logic      w_pop;
        logic      w_done;
        logic      w_ready;
        logic      w_xbuf_wr;
        logic [15:0] w_rd;
        tx_state_t r_tx_state;
        tx_state_t w_tx_next;
        logic      r_ovr;
        logic      r_rie;
        logic      r_xie;
        logic [7:0] r_xbuf;

        assign w_sel[k]   = (i_addr[15:3] == BASE[15:3]);
        assign w_rbuf_rd  = i_rd & w_sel[k] & (w_ofs == RBUF_OFS);
        assign w_pop      = w_rbuf_rd & ~w_empty;
        assign w_done     = ~w_empty;
        assign w_ready    = (r_tx_state == TX_IDLE) & i_tx_ready[k];
        assign w_xbuf_wr  = w_wr_lo & w_sel[k] & (w_ofs == XBUF_OFS);

        dl11_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .i_push  (i_rx_valid[k]),
            .i_pop   (w_pop),
            .i_data  (i_rx_data[8*k +: 8]),
            .o_head  (w_head),
            .o_full  (w_full),
            .o_empty (w_empty)
        );

        always_ff @(posedge i_clk) begin
            if (i_reset) begin
                r_ovr  <= 1'b0;
                r_rie  <= 1'b0;
                r_xie  <= 1'b0;
                r_xbuf <= 8'h00;
            end else begin
                if (i_rx_valid[k] & w_full & ~w_pop)
                    r_ovr <= 1'b1;
                else if (w_rbuf_rd)
                    r_ovr <= 1'b0;
                if (w_wr_lo & w_sel[k] & (w_ofs == RCSR_OFS))
                    r_rie <= i_wdata[IE_BIT];
                if (w_wr_lo & w_sel[k] & (w_ofs == XCSR_OFS))
                    r_xie <= i_wdata[IE_BIT];
                // XBUF always takes the data; only a write while READY sends it.
                if (w_xbuf_wr)
                    r_xbuf <= i_wdata[7:0];
            end
        end

        always_ff @(posedge i_clk) begin
            if (i_reset)
                r_tx_state <= TX_IDLE;
            else
                r_tx_state <= w_tx_next;
        end

        always_comb begin
            w_tx_next = r_tx_state;
            case (r_tx_state)
                TX_IDLE: if (w_xbuf_wr & w_ready) w_tx_next = TX_SEND;
                TX_SEND: if (~i_tx_ready[k])      w_tx_next = TX_WAIT;
                TX_WAIT: if (i_tx_ready[k])       w_tx_next = TX_IDLE;
                default:                          w_tx_next = TX_IDLE;
            endcase
        end

        always_comb begin
            w_rd = 16'h0000;
            if (w_sel[k]) begin
                case (w_ofs)
                    RCSR_OFS: begin
                        w_rd[DONE_BIT] = w_done;
                        w_rd[IE_BIT]   = r_rie;
                    end
                    RBUF_OFS: begin
                        w_rd[7:0]     = w_head;
                        w_rd[OVR_BIT] = r_ovr;
                        w_rd[ERR_BIT] = r_ovr;
                    end
                    XCSR_OFS: begin
                        w_rd[DONE_BIT] = w_ready;
                        w_rd[IE_BIT]   = r_xie;
                    end
                    XBUF_OFS: w_rd[7:0] = r_xbuf;
                    default:  w_rd = 16'h0000;
                endcase
            end
        end

        assign w_rd_all[16*k +: 16] = w_rd;
        assign o_tx_send[k]         = (r_tx_state == TX_SEND);
        assign o_tx_data[8*k +: 8]  = r_xbuf;
        assign o_rx_irq[k]          = w_done & r_rie;
        assign o_tx_irq[k]          = w_ready & r_xie;
    end

    always_comb begin
        o_rdata = 16'h0000;
        for (int i = 0; i < NCH; i++)
            o_rdata = o_rdata | w_rd_all[16*i +: 16];
    end

    assign o_hit = |w_sel;

endmodule

// File: tb/tb_dl11_multi.sv
module tb_dl11_multi;

    localparam int NCH = 2;

    logic             clk = 1'b0;
    logic             i_reset;
    logic [15:0]      i_addr;
    logic [15:0]      i_wdata;
    logic             i_rd;
    logic             i_wr;
    logic             i_byte;
    logic [15:0]      o_rdata;
    logic             o_hit;
    logic [8*NCH-1:0] i_rx_data;
    logic [NCH-1:0]   i_rx_valid;
    logic [8*NCH-1:0] o_tx_data;
    logic [NCH-1:0]   o_tx_send;
    logic [NCH-1:0]   i_tx_ready;
    logic [NCH-1:0]   o_rx_irq;
    logic [NCH-1:0]   o_tx_irq;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dl11_multi #(.NCH(NCH), .FIFO_DEPTH(16)) dut (
        .i_clk      (clk),
        .i_reset    (i_reset),
        .i_addr     (i_addr),
        .i_wdata    (i_wdata),
        .i_rd       (i_rd),
        .i_wr       (i_wr),
        .i_byte     (i_byte),
        .o_rdata    (o_rdata),
        .o_hit      (o_hit),
        .i_rx_data  (i_rx_data),
        .i_rx_valid (i_rx_valid),
        .o_tx_data  (o_tx_data),
        .o_tx_send  (o_tx_send),
        .i_tx_ready (i_tx_ready),
        .o_rx_irq   (o_rx_irq),
        .o_tx_irq   (o_tx_irq)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %06o (0x%04h), expected %06o (0x%04h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Look at a register without any strobe.
    task automatic peek(input logic [15:0] a, output logic [15:0] d);
        i_addr = a;
        #1 d = o_rdata;
    endtask

    // Strobed read: data sampled before the edge that applies side effects.
    task automatic rd(input logic [15:0] a, output logic [15:0] d);
        i_addr = a;
        i_rd   = 1'b1;
        #1 d = o_rdata;
        tick();
        i_rd = 1'b0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d, input logic b);
        i_addr  = a;
        i_wdata = d;
        i_byte  = b;
        i_wr    = 1'b1;
        tick();
        i_wr   = 1'b0;
        i_byte = 1'b0;
    endtask

    task automatic push(input int ch, input logic [7:0] b);
        i_rx_data[8*ch +: 8] = b;
        i_rx_valid[ch]       = 1'b1;
        tick();
        i_rx_valid = '0;
    endtask

    initial begin
        logic [15:0] d;

        i_reset    = 1'b1;
        i_addr     = 16'h0000;
        i_wdata    = 16'h0000;
        i_rd       = 1'b0;
        i_wr       = 1'b0;
        i_byte     = 1'b0;
        i_rx_data  = '0;
        i_rx_valid = '0;
        i_tx_ready = '1;
        repeat (3) tick();
        i_reset = 1'b0;
        tick();

        // Reset state
        peek(16'o177560, d); check("rst_rcsr0", d, 16'o000000);
        peek(16'o177564, d); check("rst_xcsr0", d, 16'o000200);
        check("rst_hit", {15'd0, o_hit}, 16'd1);
        check("rst_rx_irq", {14'd0, o_rx_irq}, 16'd0);
        check("rst_tx_irq", {14'd0, o_tx_irq}, 16'd0);
        check("rst_tx_send", {14'd0, o_tx_send}, 16'd0);
        peek(16'o160000, d); check("miss_hit", {15'd0, o_hit}, 16'd0);

        // Channel 1 receive
        push(1, 8'h41);
        push(1, 8'h42);
        peek(16'o176500, d); check("ch1_rcsr_done", d, 16'o000200);
        peek(16'o177560, d); check("ch0_rcsr_idle", d, 16'o000000);
        rd(16'o176502, d);   check("ch1_rbuf_a", d, 16'h0041);
        rd(16'o176502, d);   check("ch1_rbuf_b", d, 16'h0042);
        peek(16'o176500, d); check("ch1_rcsr_empty", d, 16'o000000);

        // Channel 0 overrun: 17 pushes into 16 entries
        for (int i = 0; i < 17; i++) push(0, 8'(8'h10 + i));
        peek(16'o177562, d); check("ovr_rbuf", d, 16'o140000 | 16'h0010);
        rd(16'o177562, d);   check("ovr_pop", d, 16'hC010);
        peek(16'o177562, d); check("ovr_cleared", d, 16'h0011);
        push(0, 8'h20);
        // Full FIFO: push and pop together
        i_rx_data[7:0] = 8'h21;
        i_rx_valid     = 2'b01;
        i_addr         = 16'o177562;
        i_rd           = 1'b1;
        #1 check("full_pushpop_rd", o_rdata, 16'h0011);
        tick();
        i_rd       = 1'b0;
        i_rx_valid = '0;
        peek(16'o177562, d); check("full_pushpop_noovr", d, 16'h0012);
        // Still full: one more push must overrun
        push(0, 8'h99);
        peek(16'o177562, d); check("still_full_ovr", d, 16'hC012);
        rd(16'o177562, d);   check("drain_0", d, 16'hC012);
        for (int i = 1; i < 16; i++) begin
            rd(16'o177562, d);
            check($sformatf("drain_%0d", i), d, 16'(8'h12 + i));
        end
        peek(16'o177560, d); check("drained_rcsr", d, 16'o000000);

        // Transmit channel 0
        wr(16'o177566, 16'h0055, 1'b0);
        check("tx_send_rise", {14'd0, o_tx_send}, 16'b01);
        check("tx_data", o_tx_data, 16'h0055);
        peek(16'o177564, d); check("tx_busy_xcsr", d, 16'o000000);
        wr(16'o177566, 16'h0066, 1'b0);
        peek(16'o177566, d); check("tx_xbuf_upd", d, 16'h0066);
        check("tx_still_send", {14'd0, o_tx_send}, 16'b01);
        i_tx_ready = 2'b10;
        tick();
        check("tx_wait_send", {14'd0, o_tx_send}, 16'b00);
        peek(16'o177564, d); check("tx_wait_xcsr", d, 16'o000000);
        i_tx_ready = 2'b11;
        tick();
        peek(16'o177564, d); check("tx_idle_xcsr", d, 16'o000200);
        repeat (2) tick();
        check("tx_no_resend", {14'd0, o_tx_send}, 16'b00);

        // Interrupt enables
        wr(16'o177560, 16'o000100, 1'b0);
        check("rie_empty_irq", {14'd0, o_rx_irq}, 16'b00);
        wr(16'o177564, 16'o000100, 1'b0);
        check("xie_irq", {14'd0, o_tx_irq}, 16'b01);
        push(0, 8'h33);
        check("rx_irq_on", {14'd0, o_rx_irq}, 16'b01);
        peek(16'o177560, d); check("rcsr_rie_done", d, 16'o000300);
        wr(16'o177561, 16'h0000, 1'b1);
        check("odd_byte_keep_rie", {14'd0, o_rx_irq}, 16'b01);
        rd(16'o177562, d);   check("irq_pop", d, 16'h0033);
        check("rx_irq_off", {14'd0, o_rx_irq}, 16'b00);
        wr(16'o177566, 16'h0077, 1'b0);
        check("tx_irq_busy", {14'd0, o_tx_irq}, 16'b00);

        // Reset in the middle of activity
        for (int i = 0; i < 5; i++) push(0, 8'(8'hA0 + i));
        check("pre_rst_send", {14'd0, o_tx_send}, 16'b01);
        check("pre_rst_irq", {14'd0, o_rx_irq}, 16'b01);
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        peek(16'o177560, d); check("mid_rst_rcsr", d, 16'o000000);
        peek(16'o177564, d); check("mid_rst_xcsr", d, 16'o000200);
        check("mid_rst_send", {14'd0, o_tx_send}, 16'b00);
        check("mid_rst_txdata", o_tx_data, 16'h0000);
        check("mid_rst_rx_irq", {14'd0, o_rx_irq}, 16'b00);
        check("mid_rst_tx_irq", {14'd0, o_tx_irq}, 16'b00);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
